calc_operand_sequencer: RTL and testbench

//  Byte-addressed front end for the calculator; sits between the I2C slave register port and the calculator core.

---
 rtl/calc_operand_sequencer.sv | 119 +++++++++++
 tb/tb_calc_operand_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_operand_sequencer.sv
// Byte-mapped operand/opcode front end and result capture for the calculator core.
// Optional CALC_SEQ_AUTOSTART_EN: a write to 0x07 (B MSB) in IDLE also starts an operation.
module calc_operand_sequencer #(
   parameter int CALC_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [7:0]  wr_data,
   input  logic [4:0]  rd_addr,
   output logic [7:0]  rd_data,
   output logic [31:0] calc_a,
   output logic [31:0] calc_b,
   output logic [1:0]  calc_op,
   input  logic [63:0] calc_result,
   output logic        busy,
   output logic        done
);

   localparam logic [3:0] LAT = 4'(CALC_LATENCY);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state, state_nx;
   logic [31:0] a_q, b_q, b_nx;
   logic [1:0]  op_q, op_nx;
   logic [63:0] res_q;
   logic [3:0]  cnt_q;
   logic        valid_q, div0_q, ovr_q, done_q;
   logic        wr_ctrl, start_req, accept, finish;
   logic [7:0]  rd_nx;

   always_comb begin
      wr_ctrl = wr_en && (wr_addr == 5'h08);
`ifdef CALC_SEQ_AUTOSTART_EN
      start_req = (wr_ctrl && wr_data[7]) || (wr_en && (wr_addr == 5'h07));
`else
      start_req = wr_ctrl && wr_data[7];
`endif
      accept = start_req && (state == IDLE);
      finish = (state == WAIT) && (cnt_q == LAT);
      op_nx  = wr_ctrl ? wr_data[1:0] : op_q;
      // div0 must see the byte landing on the start edge
      b_nx   = b_q;
      if (wr_en && (wr_addr[4:2] == 3'b001))
         b_nx[{wr_addr[1:0], 3'b000} +: 8] = wr_data;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = WAIT;
         WAIT: if (finish) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         div0_q  <= 1'b0;
         ovr_q   <= 1'b0;
         done_q  <= 1'b0;
         rd_data <= '0;
      end else begin
         done_q  <= finish;
         rd_data <= rd_nx;
         if (wr_en && (state == IDLE)) begin
            if (wr_addr[4:2] == 3'b000)
               a_q[{wr_addr[1:0], 3'b000} +: 8] <= wr_data;
            b_q  <= b_nx;
            op_q <= op_nx;
         end
         if (state == WAIT) cnt_q <= cnt_q + 4'd1;
         if (accept) begin
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            div0_q  <= (op_nx == 2'd3) && (b_nx == '0);
         end else if (start_req) begin
            ovr_q <= 1'b1;
         end
         if (finish) begin
            res_q   <= calc_result;
            valid_q <= 1'b1;
         end
      end
   end

   always_comb begin
      rd_nx = 8'h00;
      unique case (1'b1)
         (rd_addr[4:2] == 3'b000): rd_nx = a_q[{rd_addr[1:0], 3'b000} +: 8];
         (rd_addr[4:2] == 3'b001): rd_nx = b_q[{rd_addr[1:0], 3'b000} +: 8];
         (rd_addr == 5'h08):       rd_nx = {6'b0, op_q};
         (rd_addr == 5'h09):       rd_nx = {4'b0, ovr_q, div0_q, valid_q, busy};
         (rd_addr[4:3] == 2'b10):  rd_nx = res_q[{rd_addr[2:0], 3'b000} +: 8];
         default:                  rd_nx = 8'h00;
      endcase
   end

   assign busy    = (state == WAIT);
   assign done    = done_q;
   assign calc_a  = a_q;
   assign calc_b  = b_q;
   assign calc_op = op_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Randomised bench for calc_operand_sequencer: two instances (latency 1 and 4)
// checked against an edge-indexed transaction model of the register map.
module tb_calc_operand_sequencer;

`ifdef CALC_SEQ_AUTOSTART_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   localparam logic [63:0] POISON = 64'hBADC0FFEE0DDF00D;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [4:0]  rd_addr = '0;
   logic [7:0]  wr_data = '0;
   logic [7:0]  rdd [2];
   logic [31:0] ca [2];
   logic [31:0] cb [2];
   logic [1:0]  cop [2];
   logic [63:0] cres [2];
   logic        bsy [2];
   logic        dn [2];
   bit          en [2] = '{1'b1, 1'b1};

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int dcnt [2] = '{0, 0};
   int stab [2] = '{0, 0};
   logic [31:0] pa [2];
   logic [31:0] pb [2];
   logic [1:0]  pop [2];

   // transaction model, indexed by posedge number
   logic [31:0] ma [2];
   logic [31:0] mb [2];
   logic [1:0]  mop [2];
   logic [63:0] mres [2];
   logic [63:0] mpres [2];
   bit          mvalid [2], mdiv0 [2], movr [2], mpend [2];
   int          mstart [2], mend [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   calc_operand_sequencer #(.CALC_LATENCY(1)) u1 (
      .clk(clk), .rst(rst), .wr_en(wr_en & en[0]), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rdd[0]),
      .calc_a(ca[0]), .calc_b(cb[0]), .calc_op(cop[0]),
      .calc_result(cres[0]), .busy(bsy[0]), .done(dn[0]));

   calc_operand_sequencer #(.CALC_LATENCY(4)) u4 (
      .clk(clk), .rst(rst), .wr_en(wr_en & en[1]), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rdd[1]),
      .calc_a(ca[1]), .calc_b(cb[1]), .calc_op(cop[1]),
      .calc_result(cres[1]), .busy(bsy[1]), .done(dn[1]));

   function automatic int lat(int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic logic [63:0] ref_fn(logic [31:0] a, logic [31:0] b, logic [1:0] op);
      case (op)
         2'd0: return {32'h0, a + b};
         2'd1: return {32'h0, a - b};
         2'd2: return {32'h0, a} * {32'h0, b};
         default: return (b == 0) ? 64'h0 : {32'h0, a / b};
      endcase
   endfunction

   // core stand-in: result is garbage until operands held for LAT edges
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (ca[i] !== pa[i] || cb[i] !== pb[i] || cop[i] !== pop[i]) stab[i] <= 0;
         else if (stab[i] < 15) stab[i] <= stab[i] + 1;
         pa[i] <= ca[i];
         pb[i] <= cb[i];
         pop[i] <= cop[i];
         if (dn[i] === 1'b1) dcnt[i] <= dcnt[i] + 1;
      end
   end
   assign cres[0] = (stab[0] >= 1) ? ref_fn(ca[0], cb[0], cop[0]) : POISON;
   assign cres[1] = (stab[1] >= 4) ? ref_fn(ca[1], cb[1], cop[1]) : POISON;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         ma[i] = '0; mb[i] = '0; mop[i] = '0; mres[i] = '0; mpres[i] = '0;
         mvalid[i] = 0; mdiv0[i] = 0; movr[i] = 0; mpend[i] = 0;
         mstart[i] = -10; mend[i] = -10;
      end
   endfunction

   function automatic void settle(int i, int e);
      if (mpend[i] && mend[i] <= e) begin
         mres[i] = mpres[i];
         mvalid[i] = 1;
         mpend[i] = 0;
      end
   endfunction

   function automatic bit mbusy(int i);
      return (cyc >= mstart[i]) && (cyc < mend[i]);
   endfunction

   function automatic bit mdone(int i);
      return cyc == mend[i];
   endfunction

   function automatic logic [7:0] mread(int i, logic [4:0] ad, int e);
      int k = int'(ad);
      bit bp = (e - 1 >= mstart[i]) && (e - 1 < mend[i]);
      if (k < 4) return ma[i][8*k +: 8];
      if (k < 8) return mb[i][8*(k-4) +: 8];
      if (k == 8) return {6'b0, mop[i]};
      if (k == 9) return {4'b0, movr[i], mdiv0[i], mvalid[i], bp};
      if (k >= 16 && k < 24) return mres[i][8*(k-16) +: 8];
      return 8'h00;
   endfunction

   function automatic void model_write(int i, int e, logic [4:0] ad, logic [7:0] d);
      int k = int'(ad);
      bit st;
      if (!en[i]) return;
      st = (k == 8 && d[7]) || (AUTO && k == 7);
      if (e > mstart[i] && e <= mend[i]) begin
         if (st) movr[i] = 1;
         return;
      end
      if (k < 4) ma[i][8*k +: 8] = d;
      else if (k < 8) mb[i][8*(k-4) +: 8] = d;
      else if (k == 8) mop[i] = d[1:0];
      if (st) begin
         mstart[i] = e;
         mend[i] = e + 1 + lat(i);
         movr[i] = 0;
         mvalid[i] = 0;
         mdiv0[i] = (mop[i] == 2'd3) && (mb[i] == 0);
         mpres[i] = ref_fn(ma[i], mb[i], mop[i]);
         mpend[i] = 1;
      end
   endfunction

   // one clock of stimulus; returns the read data expected after this edge
   task automatic drive(input bit we, input logic [4:0] wa, input logic [7:0] wd,
                        input logic [4:0] ra, output logic [7:0] e0, output logic [7:0] e1);
      int e = cyc + 1;
      for (int i = 0; i < 2; i++) settle(i, e - 1);
      e0 = mread(0, ra, e);
      e1 = mread(1, ra, e);
      if (we) for (int i = 0; i < 2; i++) model_write(i, e, wa, wd);
      wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
      @(negedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] e0, e1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (bsy[i] !== 1'b0 || dn[i] !== 1'b0 || rdd[i] !== 8'h00 ||
             ca[i] !== 32'h0 || cb[i] !== 32'h0 || cop[i] !== 2'd0) begin
            failures++;
            $display("FAIL reset dut%0d busy=%0b done=%0b rd=%h a=%h b=%h op=%0d (want all 0)",
                     i, bsy[i], dn[i], rdd[i], ca[i], cb[i], cop[i]);
         end
      end
      rst = 1'b0;
      model_reset();
      for (int ad = 0; ad < 24; ad++) begin
         drive(0, 0, 0, 5'(ad), e0, e1);
         checks++;
         if (rdd[0] !== e0 || rdd[1] !== e1) begin
            failures++;
            $display("FAIL reset_read addr=%h got=%h/%h want=%h/%h", ad, rdd[0], rdd[1], e0, e1);
         end
      end
   endtask

   task automatic test_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] ctrl);
      logic [7:0] e0, e1;
      logic [7:0] er [2];
      int d0 [2];
      for (int i = 0; i < 2; i++) d0[i] = dcnt[i];
      for (int k = 0; k < 4; k++) drive(1, 5'(k), a[8*k +: 8], 0, e0, e1);
      for (int k = 0; k < 4; k++) drive(1, 5'(4 + k), b[8*k +: 8], 0, e0, e1);
      drive(1, 5'h08, ctrl, 0, e0, e1);
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (bsy[i] !== mbusy(i) || dn[i] !== mdone(i) || ca[i] !== ma[i] ||
                cb[i] !== mb[i] || cop[i] !== mop[i]) begin
               failures++;
               $display("FAIL %s flags dut%0d cyc=%0d busy=%0b/%0b done=%0b/%0b a=%h/%h b=%h/%h op=%0d/%0d",
                        nm, i, cyc, bsy[i], mbusy(i), dn[i], mdone(i), ca[i], ma[i],
                        cb[i], mb[i], cop[i], mop[i]);
            end
         end
         drive(0, 0, 0, 0, e0, e1);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (dcnt[i] - d0[i] != 1) begin
            failures++;
            $display("FAIL %s done_count dut%0d got=%0d want=1", nm, i, dcnt[i] - d0[i]);
         end
      end
      for (int ad = 16; ad <= 24; ad++) begin
         logic [4:0] ra = (ad == 24) ? 5'h09 : 5'(ad);
         drive(0, 0, 0, ra, er[0], er[1]);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (rdd[i] !== er[i]) begin
               failures++;
               $display("FAIL %s read dut%0d addr=%h got=%h want=%h", nm, i, ra, rdd[i], er[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         logic [31:0] a = $urandom;
         logic [31:0] b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         logic [1:0] op = 2'($urandom_range(0, 3));
         test_op("random", a, b, {6'b100000, op});
      end
   endtask

   task automatic test_overrun();
      logic [7:0] e0, e1;
      logic [7:0] er [2];
      int d0 [2];
      for (int i = 0; i < 2; i++) d0[i] = dcnt[i];
      drive(1, 5'h08, 8'h80, 0, e0, e1);
      drive(1, 5'h00, 8'h55, 0, e0, e1);
      drive(1, 5'h08, 8'h80, 0, e0, e1);
      repeat (6) drive(0, 0, 0, 0, e0, e1);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (dcnt[i] - d0[i] != 1) begin
            failures++;
            $display("FAIL overrun done_count dut%0d got=%0d want=1", i, dcnt[i] - d0[i]);
         end
      end
      drive(0, 0, 0, 5'h00, er[0], er[1]);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (rdd[i] !== er[i]) begin
            failures++;
            $display("FAIL overrun a0 dut%0d got=%h want=%h", i, rdd[i], er[i]);
         end
      end
      drive(0, 0, 0, 5'h09, er[0], er[1]);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (rdd[i] !== er[i] || rdd[i][3] !== 1'b1) begin
            failures++;
            $display("FAIL overrun status dut%0d got=%h want=%h", i, rdd[i], er[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e0, e1;
      int d0 = dcnt[0];
      en[1] = 1'b0;
      drive(1, 5'h08, 8'h80, 0, e0, e1);
      drive(0, 0, 0, 0, e0, e1);
      drive(1, 5'h08, 8'h81, 0, e0, e1);
      checks++;
      if (dn[0] !== 1'b1 || bsy[0] !== 1'b0 || mdone(0) !== 1'b1) begin
         failures++;
         $display("FAIL same_edge done=%0b busy=%0b want done=1 busy=0", dn[0], bsy[0]);
      end
      drive(1, 5'h08, 8'h80, 5'h09, e0, e1);
      checks++;
      if (rdd[0] !== e0 || bsy[0] !== 1'b1) begin
         failures++;
         $display("FAIL back_to_back status got=%h busy=%0b want=%h busy=1", rdd[0], bsy[0], e0);
      end
      for (int c = 0; c < 4; c++) begin
         drive(0, 0, 0, 5'h09, e0, e1);
         checks++;
         if (bsy[0] !== mbusy(0) || dn[0] !== mdone(0) || rdd[0] !== e0) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d busy=%0b/%0b done=%0b/%0b status=%h/%h",
                     cyc, bsy[0], mbusy(0), dn[0], mdone(0), rdd[0], e0);
         end
      end
      checks++;
      if (dcnt[0] - d0 != 2) begin
         failures++;
         $display("FAIL back_to_back done_count got=%0d want=2", dcnt[0] - d0);
      end
      en[1] = 1'b1;
   endtask

   task automatic test_autostart();
      logic [7:0] e0, e1;
      logic [7:0] er [2];
      int d0 [2];
      for (int i = 0; i < 2; i++) d0[i] = dcnt[i];
      drive(1, 5'h08, 8'h01, 0, e0, e1);
      drive(1, 5'h00, 8'd10, 0, e0, e1);
      for (int k = 1; k < 4; k++) drive(1, 5'(k), 8'h00, 0, e0, e1);
      drive(1, 5'h04, 8'd4, 0, e0, e1);
      drive(1, 5'h05, 8'h00, 0, e0, e1);
      drive(1, 5'h06, 8'h00, 0, e0, e1);
      drive(1, 5'h07, 8'h00, 0, e0, e1);
      for (int c = 0; c < 7; c++) begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (bsy[i] !== mbusy(i) || dn[i] !== mdone(i)) begin
               failures++;
               $display("FAIL autostart flags dut%0d cyc=%0d busy=%0b/%0b done=%0b/%0b",
                        i, cyc, bsy[i], mbusy(i), dn[i], mdone(i));
            end
         end
         drive(0, 0, 0, 0, e0, e1);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (dcnt[i] - d0[i] != int'(AUTO)) begin
            failures++;
            $display("FAIL autostart done_count dut%0d got=%0d want=%0d", i, dcnt[i] - d0[i], AUTO);
         end
      end
      drive(0, 0, 0, 5'h10, er[0], er[1]);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (rdd[i] !== er[i]) begin
            failures++;
            $display("FAIL autostart result dut%0d got=%h want=%h", i, rdd[i], er[i]);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [7:0] e0, e1;
      logic [7:0] er [2];
      int d0 [2];
      drive(1, 5'h08, 8'h80, 0, e0, e1);
      drive(0, 0, 0, 0, e0, e1);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         d0[i] = dcnt[i];
         checks++;
         if (bsy[i] !== 1'b0 || dn[i] !== 1'b0 || rdd[i] !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid dut%0d busy=%0b done=%0b rd=%h want 0/0/00", i, bsy[i], dn[i], rdd[i]);
         end
      end
      @(negedge clk); #1;
      rst = 1'b0;
      model_reset();
      repeat (6) drive(0, 0, 0, 5'h10, e0, e1);
      for (int ad = 0; ad < 2; ad++) begin
         logic [4:0] ra = (ad == 0) ? 5'h10 : 5'h09;
         drive(0, 0, 0, ra, er[0], er[1]);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (rdd[i] !== er[i] || rdd[i] !== 8'h00 || dcnt[i] != d0[i]) begin
               failures++;
               $display("FAIL reset_mid read dut%0d addr=%h got=%h want=%h dones=%0d",
                        i, ra, rdd[i], er[i], dcnt[i] - d0[i]);
            end
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      test_reset();
      test_op("add", 32'd5, 32'd3, 8'h80);
      test_op("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h82);
      test_op("div0", 32'd7, 32'd0, 8'h83);
      test_op("div", 32'd7, 32'd2, 8'h83);
      test_op("sub_wrap", 32'd1, 32'd2, 8'h81);
      test_random();
      test_overrun();
      test_op("after_overrun", 32'd9, 32'd4, 8'h80);
      test_back_to_back();
      test_autostart();
      test_reset_mid_wait();
      test_op("post_reset", 32'h12345678, 32'h9ABCDEF0, 8'h82);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
